// File: rtl/mage_banked_dmem.sv
// mage_banked_dmem -- multi-port, multi-bank data memory with per-bank
// round-robin arbitration. N_PORTS word-addressed requesters share N_BANKS
// low-order-interleaved banks (bank = addr[log2(N_BANKS)-1:0]).
//
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   set_retentive_ni    forwarded to every bank macro
//   req_i/we_i/be_i     per-port request, write enable, byte enables
//   addr_i/wdata_i      per-port word address and write data
//   gnt_o               combinational grant, same cycle as the request
//   rvalid_o/rdata_o    read response one cycle after the grant; rdata_o is 0
//                       whenever rvalid_o is 0
//   clr_cnt_i           clear conflict counters      (MAGE_DMEM_CONFLICT_CNT_EN)
//   conflict_cnt_o      per-bank conflict counters   (MAGE_DMEM_CONFLICT_CNT_EN)
//
// Macros:
//   MAGE_DMEM_CONFLICT_CNT_EN  adds the saturating per-bank conflict counters.
//   MAGE_DMEM_SRAM_MACRO       uses sram_wrapper (fpga_sram_wrapper when
//                              FPGA_SYNTHESIS is also defined) instead of the
//                              built-in behavioural bank storage.
module mage_banked_dmem #(
    parameter int unsigned N_PORTS   = 4,
    parameter int unsigned N_BANKS   = 4,
    parameter int unsigned BANK_SIZE = 256,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned BE_W     = DATA_W / 8,
    localparam int unsigned ADDR_W   = $clog2(N_BANKS * BANK_SIZE)
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              set_retentive_ni,
    input  logic [N_PORTS-1:0]                req_i,
    input  logic [N_PORTS-1:0]                we_i,
    input  logic [N_PORTS-1:0][BE_W-1:0]      be_i,
    input  logic [N_PORTS-1:0][ADDR_W-1:0]    addr_i,
    input  logic [N_PORTS-1:0][DATA_W-1:0]    wdata_i,
    output logic [N_PORTS-1:0]                gnt_o,
    output logic [N_PORTS-1:0]                rvalid_o,
    output logic [N_PORTS-1:0][DATA_W-1:0]    rdata_o
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
    ,
    input  logic                              clr_cnt_i,
    output logic [N_BANKS-1:0][CNT_W-1:0]     conflict_cnt_o
`endif
);

    localparam int unsigned BANK_BITS = $clog2(N_BANKS);
    localparam int unsigned ROW_W     = ADDR_W - BANK_BITS;
    localparam int unsigned PORT_W    = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [N_PORTS-1:0][BANK_BITS-1:0] port_bank;
    logic [N_PORTS-1:0][ROW_W-1:0]     port_row;

    logic [N_BANKS-1:0]                bank_req;
    logic [N_BANKS-1:0][PORT_W-1:0]    bank_sel;
    logic [N_BANKS-1:0]                bank_we;
    logic [N_BANKS-1:0][BE_W-1:0]      bank_be;
    logic [N_BANKS-1:0][ROW_W-1:0]     bank_row;
    logic [N_BANKS-1:0][DATA_W-1:0]    bank_wdata;
    logic [N_BANKS-1:0][DATA_W-1:0]    bank_rdata;

    logic [N_BANKS-1:0][PORT_W-1:0]    rr_q, rr_d;
    logic [N_PORTS-1:0]                rvalid_q, rvalid_d;
    logic [N_PORTS-1:0][BANK_BITS-1:0] rbank_q, rbank_d;

    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            port_bank[p] = addr_i[p][BANK_BITS-1:0];
            port_row[p]  = addr_i[p][ADDR_W-1:BANK_BITS];
        end
    end

    // Per bank: scan ports starting at rr_q, first matching requester wins.
    // Reset masks every request so no bank access is issued.
    always_comb begin
        bank_req = '0;
        bank_sel = '0;
        gnt_o    = '0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            for (int unsigned k = 0; k < N_PORTS; k++) begin
                int unsigned idx;
                idx = int'(rr_q[b]) + k;
                if (idx >= N_PORTS) idx = idx - N_PORTS;
                if (rst_n_i && !bank_req[b] && req_i[idx] &&
                    port_bank[idx] == BANK_BITS'(b)) begin
                    bank_req[b] = 1'b1;
                    bank_sel[b] = PORT_W'(idx);
                    gnt_o[idx]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            bank_we[b]    = we_i[bank_sel[b]];
            bank_be[b]    = be_i[bank_sel[b]];
            bank_row[b]   = port_row[bank_sel[b]];
            bank_wdata[b] = wdata_i[bank_sel[b]];
            if (!bank_req[b]) begin
                rr_d[b] = rr_q[b];
            end else if (bank_sel[b] == PORT_W'(N_PORTS - 1)) begin
                rr_d[b] = '0;
            end else begin
                rr_d[b] = bank_sel[b] + 1'b1;
            end
        end
        rvalid_d = gnt_o & ~we_i;
        rbank_d  = port_bank;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_q     <= '0;
            rvalid_q <= '0;
            rbank_q  <= '0;
        end else begin
            rr_q     <= rr_d;
            rvalid_q <= rvalid_d;
            rbank_q  <= rbank_d;
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < N_PORTS; p++) begin
            rdata_o[p] = rvalid_q[p] ? bank_rdata[rbank_q[p]] : '0;
        end
    end
    assign rvalid_o = rvalid_q;

`ifdef MAGE_DMEM_SRAM_MACRO
    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
`ifdef FPGA_SYNTHESIS
        fpga_sram_wrapper #(
`else
        sram_wrapper #(
`endif
            .NUM_WORDS  (BANK_SIZE),
            .DATA_WIDTH (DATA_W)
        ) u_sram (
            .clk_i            (clk_i),
            .req_i            (bank_req[b]),
            .we_i             (bank_we[b]),
            .be_i             (bank_be[b]),
            .addr_i           (bank_row[b]),
            .wdata_i          (bank_wdata[b]),
            .rdata_o          (bank_rdata[b]),
            .set_retentive_ni (set_retentive_ni),
            .pwrgate_ni       (1'b0)
        );
    end
`else
    // Behavioural banks: byte-masked write at the grant edge, registered read.
    logic [DATA_W-1:0] mem_q [N_BANKS][BANK_SIZE];
    logic [N_BANKS-1:0][DATA_W-1:0] bank_rdata_q;
    logic unused_retentive;
    assign unused_retentive = set_retentive_ni;

    always_ff @(posedge clk_i) begin
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            if (bank_req[b] && bank_we[b]) begin
                for (int unsigned by = 0; by < BE_W; by++) begin
                    if (bank_be[b][by]) begin
                        mem_q[b][bank_row[b]][by*8 +: 8] <= bank_wdata[b][by*8 +: 8];
                    end
                end
            end
            if (bank_req[b] && !bank_we[b]) begin
                bank_rdata_q[b] <= mem_q[b][bank_row[b]];
            end
        end
    end
    assign bank_rdata = bank_rdata_q;
`endif

`ifdef MAGE_DMEM_CONFLICT_CNT_EN
    logic [N_BANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Conflict = two or more raw requests to a bank, granted or not.
    always_comb begin
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            int unsigned n;
            n = 0;
            for (int unsigned p = 0; p < N_PORTS; p++) begin
                if (req_i[p] && port_bank[p] == BANK_BITS'(b)) n = n + 1;
            end
            if (clr_cnt_i) begin
                cnt_d[b] = '0;
            end else if (n >= 2 && cnt_q[b] != '1) begin
                cnt_d[b] = cnt_q[b] + 1'b1;
            end else begin
                cnt_d[b] = cnt_q[b];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
    assign conflict_cnt_o = cnt_q;
`else
    localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_mage_banked_dmem.sv
module tb_mage_banked_dmem;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              set_ret = 1'b1;
    logic [3:0]        req, we;
    logic [3:0][3:0]   be;
    logic [3:0][9:0]   addr;
    logic [3:0][31:0]  wdata;
    logic [3:0]        gnt, rvalid;
    logic [3:0][31:0]  rdata;
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
    logic              clr;
    logic [3:0][15:0]  cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mage_banked_dmem #(
        .N_PORTS   (4),
        .N_BANKS   (4),
        .BANK_SIZE (256),
        .DATA_W    (32),
        .CNT_W     (16)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .set_retentive_ni (set_ret),
        .req_i            (req),
        .we_i             (we),
        .be_i             (be),
        .addr_i           (addr),
        .wdata_i          (wdata),
        .gnt_o            (gnt),
        .rvalid_o         (rvalid),
        .rdata_o          (rdata)
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        ,
        .clr_cnt_i        (clr),
        .conflict_cnt_o   (cnt)
`endif
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory as a flat word array with per-byte "written" flags; reads of
    // never-written bytes are not compared.
    logic [31:0] mmem   [1024];
    logic [3:0]  mknown [1024];
    int          rr_m   [4];
    bit          pend_v [4];
    logic [31:0] pend_d [4];
    logic [31:0] pend_k [4];
    int          cnt_m  [4];

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mmem[i]   = '0;
            mknown[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            rr_m[i] = 0; pend_v[i] = 0; pend_d[i] = '0; pend_k[i] = '0; cnt_m[i] = 0;
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        int         win [4];
        bit         found;
        int         pp, nreq;

        for (int p = 0; p < 4; p++) begin
            check($sformatf("rvalid[%0d]", p), 64'(rvalid[p]), 64'(pend_v[p]));
            if (!pend_v[p])
                check($sformatf("rdata_idle[%0d]", p), 64'(rdata[p]), 64'd0);
            else
                check($sformatf("rdata[%0d]", p), 64'(rdata[p] & pend_k[p]),
                      64'(pend_d[p] & pend_k[p]));
        end
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        for (int b = 0; b < 4; b++)
            check($sformatf("cnt[%0d]", b), 64'(cnt[b]), 64'(cnt_m[b]));
`endif

        eg = '0;
        for (int b = 0; b < 4; b++) begin
            win[b] = -1;
            found  = 0;
            if (rst_n) begin
                for (int k = 0; k < 4; k++) begin
                    pp = (rr_m[b] + k) % 4;
                    if (!found && req[pp] && (int'(addr[pp]) % 4) == b) begin
                        found  = 1;
                        win[b] = pp;
                        eg[pp] = 1'b1;
                    end
                end
            end
        end
        check("gnt", 64'(gnt), 64'(eg));

        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                pend_v[i] = 0; rr_m[i] = 0; cnt_m[i] = 0;
            end
        end else begin
            for (int p = 0; p < 4; p++) begin
                pend_v[p] = eg[p] && !we[p];
                if (eg[p] && !we[p]) begin
                    pend_d[p] = mmem[addr[p]];
                    for (int by = 0; by < 4; by++)
                        pend_k[p][by*8 +: 8] = {8{mknown[addr[p]][by]}};
                end
            end
            for (int p = 0; p < 4; p++) begin
                if (eg[p] && we[p]) begin
                    for (int by = 0; by < 4; by++) begin
                        if (be[p][by]) begin
                            mmem[addr[p]][by*8 +: 8] = wdata[p][by*8 +: 8];
                            mknown[addr[p]][by] = 1'b1;
                        end
                    end
                end
            end
            for (int b = 0; b < 4; b++) begin
                if (win[b] >= 0) rr_m[b] = (win[b] + 1) % 4;
                nreq = 0;
                for (int p = 0; p < 4; p++)
                    if (req[p] && (int'(addr[p]) % 4) == b) nreq++;
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
                if (clr) cnt_m[b] = 0;
                else if (nreq >= 2 && cnt_m[b] < 65535) cnt_m[b] = cnt_m[b] + 1;
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setp(input int p, input bit r, input bit w, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] e);
        req[p] = r; we[p] = w; addr[p] = a; wdata[p] = d; be[p] = e;
    endtask

    task automatic idle();
        req = '0; we = '0;
    endtask

    initial begin
        logic [3:0] gs, hold, onehot;

        rst_n = 1'b0;
        req = 4'hF; we = '0; be = '1; wdata = '0;
        for (int p = 0; p < 4; p++) addr[p] = 10'($urandom_range(0, 1023));
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        clr = 1'b0;
`endif
        // reset with every port requesting
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("rst_gnt", 64'(gnt), 64'd0);
            check("rst_rvalid", 64'(rvalid), 64'd0);
            check("rst_rdata", 64'(rdata), 64'd0);
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
            check("rst_cnt", 64'(cnt), 64'd0);
`endif
        end
        rst_n = 1'b1; idle();
        cyc();

        // write then read back through a different port
        setp(0, 1, 1, 10'd5, 32'hDEADBEEF, 4'hF);
        #1 check("wr5_gnt", 64'(gnt[0]), 64'd1);
        cyc(); idle();
        setp(1, 1, 0, 10'd5, '0, 4'h0);
        #1 check("rd5_gnt", 64'(gnt[1]), 64'd1);
        cyc(); idle();
        #1 check("rd5_rvalid", 64'(rvalid[1]), 64'd1);
        check("rd5_rdata", 64'(rdata[1]), 64'hDEADBEEF);

        // byte enables
        setp(0, 1, 1, 10'd9, 32'h11223344, 4'hF);
        cyc();
        setp(0, 1, 1, 10'd9, 32'hAABBCCDD, 4'b0101);
        cyc(); idle();
        setp(2, 1, 0, 10'd9, '0, 4'h0);
        cyc(); idle();
        #1 check("be_rdata", 64'(rdata[2]), 64'h11BB33DD);

`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        clr = 1'b1; cyc(); clr = 1'b0;
`endif
        // four ports on bank 0, each holds until granted
        for (int p = 0; p < 4; p++) setp(p, 1, 0, 10'(4 * p), '0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            onehot = 4'(1 << i);
            #1 check("conflict_gnt", 64'(gnt), 64'(onehot));
            cyc();
            req[i] = 1'b0;
        end
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        #1 check("conflict_cnt0", 64'(cnt[0]), 64'd3);
        clr = 1'b1; cyc(); clr = 1'b0;
`endif
        // one port per bank, no conflict
        for (int p = 0; p < 4; p++) setp(p, 1, 0, 10'(p), '0, 4'h0);
        #1 check("noconf_gnt", 64'(gnt), 64'hF);
        cyc(); idle();
        #1 check("noconf_rvalid", 64'(rvalid), 64'hF);
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        check("noconf_cnt", 64'(cnt), 64'd0);
`endif

        // reset while a read is in flight
        setp(0, 1, 1, 10'd20, 32'hCAFEF00D, 4'hF);
        cyc();
        setp(0, 1, 0, 10'd20, '0, 4'h0);
        #1 check("mid_gnt", 64'(gnt[0]), 64'd1);
        cyc(); idle(); rst_n = 1'b0;
        cyc();
        #1 check("mid_rvalid", 64'(rvalid[0]), 64'd0);
        rst_n = 1'b1;
        cyc();
        setp(0, 1, 0, 10'd20, '0, 4'h0);
        cyc(); idle();
        #1 check("mid_rdata", 64'(rdata[0]), 64'hCAFEF00D);
        check("mid_rvalid2", 64'(rvalid[0]), 64'd1);

        // randomized traffic, ungranted requests held (occasionally dropped)
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            gs   = gnt;
            hold = req & ~gs & {4{rst_n}};
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 199) != 0);
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
            clr = ($urandom_range(0, 49) == 0);
`endif
            for (int p = 0; p < 4; p++) begin
                if (hold[p]) begin
                    if ($urandom_range(0, 9) == 0) req[p] = 1'b0;
                end else begin
                    req[p]   = ($urandom_range(0, 2) != 0);
                    we[p]    = $urandom_range(0, 1) == 1;
                    addr[p]  = ($urandom_range(0, 3) != 0) ? 10'($urandom_range(0, 31))
                                                           : 10'($urandom_range(0, 1023));
                    be[p]    = 4'($urandom_range(0, 15));
                    wdata[p] = $urandom;
                end
            end
        end
        rst_n = 1'b1; idle();
`ifdef MAGE_DMEM_CONFLICT_CNT_EN
        clr = 1'b0;
`endif
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
